imu_i2c_target: RTL and testbench
=================================

Name: imu_i2c_target

Overview:
- Synthesizable I2C target (responder) that presents a BMI160-compatible register map to an external or on-chip I2C master.
- Serves CHIP_ID and accelerometer X/Y/Z data from parallel sample inputs; forwards register writes as strobes.
- Used as the bus-side stand-in for the IMU in loopback and hardware-in-the-loop bring-up of the accelerometer reader.

Parameters:
- SLAVE_ADDR, 7'h68, 7-bit I2C address this target responds to.
- CHIP_ID, 8'hD1, value returned at register 0x00.

Ports:
- clk_50mhz  input  1  system clock
- rst  input  1  asynchronous reset, active-high
- scl_in  input  1  bus SCL level (asynchronous)
- sda_in  input  1  bus SDA level (asynchronous)
- sda_oe  output  1  1 = pull SDA low (open-drain); 0 = release
- acc_x_in  input  16  accelerometer X sample
- acc_y_in  input  16  accelerometer Y sample
- acc_z_in  input  16  accelerometer Z sample
- wr_strobe  output  1  one-cycle pulse per written data byte
- wr_addr  output  8  register address of the write
- wr_data  output  8  written byte
- busy  output  1  high from address-match ACK until STOP/START

Behaviour:
- Reset values: sda_oe=0, wr_strobe=0, wr_addr=0, wr_data=0, busy=0, state=IDLE, reg pointer=0x00, shadow=0.
- Input conditioning: scl/sda use a 2-FF synchronizer plus a previous-value register. Edges are detected on synchronized values, giving 2–3 clk latency.
- START: sda falls while scl high. Valid in any state, including mid-byte; it aborts the current byte, releases sda_oe, and goes to ADDR.
- STOP: sda rises while scl high. Goes to IDLE, busy=0, sda_oe=0.
- Bit sampling happens on the scl rising edge. sda_oe changes only on the scl falling edge.
- FSM states: IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK.
- IDLE: waits for START.
- ADDR: shifts 8 bits MSB-first. After the 8th rising edge, compares [7:1] with SLAVE_ADDR.
  - Mismatch → IDLE, no ACK, bus untouched until the next START.
  - Match → ADDR_ACK.
- ADDR_ACK: drives sda_oe=1 from the next scl fall through the following scl fall; busy=1.
  - R/W=0 → REG.
  - R/W=1 → capture shadow, then RDATA with the first bit driven on that releasing fall.
- Shadow capture: acc_x_in, acc_y_in and acc_z_in are all latched in one clock at the ADDR_ACK entry of a read. This guarantees a coherent 6-byte burst.
- REG: shifts 8 bits into the reg pointer, then REG_ACK (ACK always) → WDATA.
- WDATA: shifts 8 bits, then WDATA_ACK (ACK always).
  - Pulses wr_strobe for one clk with wr_addr=pointer and wr_data=byte.
  - Pointer increments afterwards.
- RDATA: drives byte[pointer] MSB-first. sda_oe = ~bit, set on each scl fall.
  - After the 8th bit, releases and samples master ACK on the next scl rise.
  - ACK (sda=0) → pointer+1, continue RDATA.
  - NACK → release; wait in IDLE-equivalent for STOP/START.
- Register map: 0x00=CHIP_ID; 0x12/0x13=shadow X LSB/MSB; 0x14/0x15=Y; 0x16/0x17=Z; all other addresses read 8'h00.
- Pointer is 8-bit and wraps 0xFF→0x00. It persists across transactions, so a repeated-START read uses the pointer set by the preceding write.
- General call (address 0x00) is not acknowledged.
- Reset mid-transaction: immediate release of sda_oe and return to IDLE.

Test Plan:
- Write 0xD0, reg 0x00, repeated START, read 0xD1, 1 byte with NACK → returns 0xD1; three ACK pulses low on sda_oe; busy falls after STOP.
- acc_x_in=16'h1234, y=16'hABCD, z=16'h8001; pointer 0x12, read 6 bytes → 34 12 CD AB 01 80.
- Same burst, but change acc inputs to 16'hFFFF after byte 1 → remaining bytes are unchanged from the shadow.
- Address 0x69 (write) → sda_oe stays 0 for the whole transfer; busy=0; no wr_strobe.
- Write 0xD0, reg 0xFF, data 0x5A, 0xA5 → wr_strobe twice with (0xFF,0x5A) then (0x00,0xA5).
- Assert START after 4 data bits of a read, then a valid address → sda_oe released within 3 clk; new transaction ACKed normally. Also assert rst mid-ACK → sda_oe=0 next cycle.

Source files
------------

// File: rtl/imu_i2c_target.sv
`timescale 1ns/1ps
// I2C target presenting a BMI160-style register map: CHIP_ID plus a coherent
// X/Y/Z accelerometer snapshot for reads; register writes leave as strobes.
//
// state     | meaning
// ----------+--------------------------------------------------
// IDLE      | bus ignored until START (also post-NACK / no match)
// ADDR      | shifting in 7-bit address + R/W
// ADDR_ACK  | pulling SDA low for the address ACK
// REG       | shifting in the register pointer
// REG_ACK   | pulling SDA low for the pointer ACK
// WDATA     | shifting in a write data byte
// WDATA_ACK | pulling SDA low for the data ACK
// RDATA     | driving byte[pointer] MSB-first
// RDATA_ACK | SDA released, sampling master ACK/NACK
module imu_i2c_target #(
    parameter logic [6:0] SLAVE_ADDR = 7'h68,
    parameter logic [7:0] CHIP_ID    = 8'hD1
) (
    input  logic        clk_50mhz,
    input  logic        rst,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        sda_oe,
    input  logic [15:0] acc_x_in,
    input  logic [15:0] acc_y_in,
    input  logic [15:0] acc_z_in,
    output logic        wr_strobe,
    output logic [7:0]  wr_addr,
    output logic [7:0]  wr_data,
    output logic        busy
);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  scl_sync_q, scl_sync_d;
    logic [1:0]  sda_sync_q, sda_sync_d;
    logic        scl_prev_q, scl_prev_d;
    logic        sda_prev_q, sda_prev_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [6:0]  shift_q, shift_d;
    logic        rw_q, rw_d;
    logic [7:0]  ptr_q, ptr_d;
    logic [47:0] shadow_q, shadow_d;
    logic        sda_oe_q, sda_oe_d;
    logic        wr_strobe_q, wr_strobe_d;
    logic [7:0]  wr_addr_q, wr_addr_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic        busy_q, busy_d;

    logic       scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det, byte_done;
    logic [7:0] rx_byte, rd_byte;

    assign scl_s     = scl_sync_q[1];
    assign sda_s     = sda_sync_q[1];
    assign scl_rise  = scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s & scl_prev_q;
    assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
    assign rx_byte   = {shift_q, sda_s};
    assign byte_done = scl_rise && (bit_cnt_q == 3'd7);

    always_comb begin
        case (ptr_q)
            8'h00:   rd_byte = CHIP_ID;
            8'h12:   rd_byte = shadow_q[7:0];
            8'h13:   rd_byte = shadow_q[15:8];
            8'h14:   rd_byte = shadow_q[23:16];
            8'h15:   rd_byte = shadow_q[31:24];
            8'h16:   rd_byte = shadow_q[39:32];
            8'h17:   rd_byte = shadow_q[47:40];
            default: rd_byte = 8'h00;
        endcase
    end

    always_comb begin
        scl_sync_d  = {scl_sync_q[0], scl_in};
        sda_sync_d  = {sda_sync_q[0], sda_in};
        scl_prev_d  = scl_s;
        sda_prev_d  = sda_s;
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        rw_d        = rw_q;
        ptr_d       = ptr_q;
        shadow_d    = shadow_q;
        sda_oe_d    = sda_oe_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        busy_d      = busy_q;

        if (start_det) begin
            state_d   = ADDR;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
        end else if (stop_det) begin
            state_d  = IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else begin
            if (scl_rise && (state_q == ADDR || state_q == REG || state_q == WDATA)) begin
                shift_d   = rx_byte[6:0];
                bit_cnt_d = bit_cnt_q + 3'd1;
            end
            case (state_q)
                ADDR: if (byte_done) begin
                    // general call (0x00) is never acknowledged, whatever SLAVE_ADDR is
                    if (rx_byte[7:1] == SLAVE_ADDR && rx_byte[7:1] != 7'h00) begin
                        state_d = ADDR_ACK;
                        rw_d    = rx_byte[0];
                        busy_d  = 1'b1;
                        if (rx_byte[0]) shadow_d = {acc_z_in, acc_y_in, acc_x_in};
                    end else begin
                        state_d = IDLE;
                    end
                end
                REG: if (byte_done) begin
                    ptr_d   = rx_byte;
                    state_d = REG_ACK;
                end
                WDATA: if (byte_done) begin
                    wr_strobe_d = 1'b1;
                    wr_addr_d   = ptr_q;
                    wr_data_d   = rx_byte;
                    ptr_d       = ptr_q + 8'd1;
                    state_d     = WDATA_ACK;
                end
                ADDR_ACK, REG_ACK, WDATA_ACK: if (scl_fall) begin
                    if (!sda_oe_q) begin
                        sda_oe_d = 1'b1;
                    end else begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = '0;
                        if (state_q != ADDR_ACK) begin
                            state_d = WDATA;
                        end else if (rw_q) begin
                            state_d  = RDATA;
                            sda_oe_d = ~rd_byte[7];
                        end else begin
                            state_d = REG;
                        end
                    end
                end
                RDATA: begin
                    // bit_cnt counts bits already clocked out, so ~bit_cnt is the next bit index
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) state_d = RDATA_ACK;
                    end else if (scl_fall) begin
                        sda_oe_d = ~rd_byte[~bit_cnt_q];
                    end
                end
                RDATA_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d = 1'b0;
                    end else if (scl_rise) begin
                        if (!sda_s) begin
                            ptr_d     = ptr_q + 8'd1;
                            bit_cnt_d = '0;
                            state_d   = RDATA;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_50mhz or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            scl_sync_q  <= 2'b11;
            sda_sync_q  <= 2'b11;
            scl_prev_q  <= 1'b1;
            sda_prev_q  <= 1'b1;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            rw_q        <= 1'b0;
            ptr_q       <= '0;
            shadow_q    <= '0;
            sda_oe_q    <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            scl_sync_q  <= scl_sync_d;
            sda_sync_q  <= sda_sync_d;
            scl_prev_q  <= scl_prev_d;
            sda_prev_q  <= sda_prev_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            rw_q        <= rw_d;
            ptr_q       <= ptr_d;
            shadow_q    <= shadow_d;
            sda_oe_q    <= sda_oe_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            busy_q      <= busy_d;
        end
    end

    assign sda_oe    = sda_oe_q;
    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_imu_i2c_target.sv
`timescale 1ns/1ps
// Bench for imu_i2c_target: bit-banged I2C master, transaction-level register-map
// model, and a per-cycle monitor comparing sda_oe/busy/wr_* against the model.
module tb_imu_i2c_target;
    localparam int Q = 6;
    localparam logic [7:0] BURST [6] = '{8'h34, 8'h12, 8'hCD, 8'hAB, 8'h01, 8'h80};

    logic        clk_50mhz = 1'b0;
    logic        rst = 1'b1;
    logic        scl_m = 1'b1, sda_m = 1'b1;
    logic        scl_in, sda_in, sda_oe, wr_strobe, busy, sda_line;
    logic [15:0] acc_x, acc_y, acc_z;
    logic [7:0]  wr_addr, wr_data;

    assign sda_line = sda_m & ~sda_oe;
    assign scl_in   = scl_m;
    assign sda_in   = sda_line;

    always #10 clk_50mhz = ~clk_50mhz;

    imu_i2c_target dut (
        .clk_50mhz(clk_50mhz), .rst(rst), .scl_in(scl_in), .sda_in(sda_in),
        .sda_oe(sda_oe), .acc_x_in(acc_x), .acc_y_in(acc_y), .acc_z_in(acc_z),
        .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
    );

    int checks = 0, failures = 0;
    logic chk_en = 1'b0, exp_oe = 1'b0;

    // transaction-level model of the target
    logic [7:0]  m_ptr = 8'h00;
    logic        m_busy = 1'b0;
    logic [15:0] m_sx = '0, m_sy = '0, m_sz = '0;
    logic [15:0] exp_wq[$];
    logic [7:0]  st_addr[$], st_data[$];

    function automatic logic [7:0] mdl_reg(input logic [7:0] a);
        case (a)
            8'h00:   return 8'hD1;
            8'h12:   return m_sx[7:0];
            8'h13:   return m_sx[15:8];
            8'h14:   return m_sy[7:0];
            8'h15:   return m_sy[15:8];
            8'h16:   return m_sz[7:0];
            8'h17:   return m_sz[15:8];
            default: return 8'h00;
        endcase
    endfunction

    task automatic chk1(input string name, input logic act, input logic want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, want, $time);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
        end
    endtask

    task automatic chk32(input string name, input int act, input int want);
        checks++;
        if (act != want) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, want, $time);
        end
    endtask

    always @(negedge clk_50mhz) begin
        logic [15:0] e;
        if (!rst) begin
            if (wr_strobe) begin
                st_addr.push_back(wr_addr);
                st_data.push_back(wr_data);
                if (exp_wq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL wr_strobe: got strobe addr=%h data=%h expected none", wr_addr, wr_data);
                end else begin
                    e = exp_wq.pop_front();
                    chk8("wr_addr", wr_addr, e[15:8]);
                    chk8("wr_data", wr_data, e[7:0]);
                end
            end
            if (chk_en) chk1("sda_oe", sda_oe, exp_oe);
            if (chk_en && !scl_m) chk1("busy", busy, m_busy);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_50mhz);
        #2;
    endtask

    task automatic clock_bit(input logic m_sda, input logic exp_drive, output logic ln);
        cyc(2);
        sda_m = m_sda;
        cyc(Q);
        exp_oe = exp_drive;
        chk_en = 1'b1;
        cyc(Q);
        scl_m = 1'b1;
        cyc(Q);
        ln = sda_line;
        cyc(Q);
        chk_en = 1'b0;
        scl_m  = 1'b0;
    endtask

    task automatic i2c_start();
        chk_en = 1'b0;
        cyc(2);
        sda_m = 1'b1;
        cyc(Q);
        scl_m = 1'b1;
        cyc(Q);
        sda_m  = 1'b0;
        m_busy = 1'b0;
        cyc(Q);
        scl_m = 1'b0;
    endtask

    task automatic i2c_stop();
        chk_en = 1'b0;
        cyc(2);
        sda_m = 1'b0;
        cyc(Q);
        scl_m = 1'b1;
        cyc(Q);
        sda_m  = 1'b1;
        m_busy = 1'b0;
        cyc(Q);
    endtask

    task automatic send_bits(input logic [7:0] b);
        logic ln;
        for (int i = 7; i >= 0; i--) clock_bit(b[i], 1'b0, ln);
    endtask

    task automatic ack_bit(input string name, input logic want_ack, output logic ln);
        clock_bit(1'b1, want_ack, ln);
        chk1(name, ln, !want_ack);
    endtask

    task automatic addr_phase(input logic [6:0] a, input logic rw, output logic ln);
        logic match;
        match = (a == 7'h68);
        send_bits({a, rw});
        if (match) begin
            m_busy = 1'b1;
            if (rw) begin
                m_sx = acc_x;
                m_sy = acc_y;
                m_sz = acc_z;
            end
        end
        ack_bit("addr_ack", match, ln);
    endtask

    task automatic reg_byte(input logic [7:0] b, output logic ln);
        send_bits(b);
        m_ptr = b;
        ack_bit("reg_ack", 1'b1, ln);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ln);
        exp_wq.push_back({m_ptr, b});
        m_ptr = m_ptr + 8'd1;
        send_bits(b);
        ack_bit("wdata_ack", 1'b1, ln);
    endtask

    task automatic read_byte(input logic m_ack, output logic [7:0] got);
        logic [7:0] e;
        logic ln;
        e = mdl_reg(m_ptr);
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b1, ~e[i], ln);
            got[i] = ln;
        end
        clock_bit(!m_ack, 1'b0, ln);
        chk8("rdata", got, e);
        if (m_ack) m_ptr = m_ptr + 8'd1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic l1, l2, l3, ln;
        logic [7:0] got, e;
        logic [7:0] b0, b1;
        int n0;
        acc_x = 16'h1234;
        acc_y = 16'hABCD;
        acc_z = 16'h8001;
        cyc(5);
        chk1("rst_sda_oe", sda_oe, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_wr_strobe", wr_strobe, 1'b0);
        chk8("rst_wr_addr", wr_addr, 8'h00);
        chk8("rst_wr_data", wr_data, 8'h00);
        rst = 1'b0;
        cyc(5);

        // CHIP_ID via write-pointer + repeated START read
        i2c_start();
        addr_phase(7'h68, 1'b0, l1);
        reg_byte(8'h00, l2);
        i2c_start();
        addr_phase(7'h68, 1'b1, l3);
        read_byte(1'b0, got);
        chk8("t1_chip_id", got, 8'hD1);
        chk8("t1_three_acks_low", {5'd0, l1, l2, l3}, 8'h00);
        chk1("t1_busy_before_stop", busy, 1'b1);
        i2c_stop();
        cyc(4);
        chk1("t1_busy_after_stop", busy, 1'b0);

        // 6-byte burst from 0x12, then again with inputs changed mid-burst
        for (int pass = 0; pass < 2; pass++) begin
            i2c_start();
            addr_phase(7'h68, 1'b0, ln);
            reg_byte(8'h12, ln);
            i2c_start();
            addr_phase(7'h68, 1'b1, ln);
            for (int i = 0; i < 6; i++) begin
                read_byte(i < 5, got);
                chk8(pass == 0 ? "t2_burst" : "t3_burst_shadow", got, BURST[i]);
                if (pass == 1 && i == 0) begin
                    acc_x = 16'hFFFF;
                    acc_y = 16'hFFFF;
                    acc_z = 16'hFFFF;
                end
            end
            i2c_stop();
        end
        acc_x = 16'h1234;
        acc_y = 16'hABCD;
        acc_z = 16'h8001;

        // wrong address and general call: bus untouched, no strobes
        n0 = st_addr.size();
        for (int k = 0; k < 2; k++) begin
            i2c_start();
            addr_phase(k == 0 ? 7'h69 : 7'h00, 1'b0, ln);
            chk1("t4_addr_nack", ln, 1'b1);
            send_bits(8'h00);
            ack_bit("t4_reg_nack", 1'b0, ln);
            send_bits(8'h55);
            ack_bit("t4_data_nack", 1'b0, ln);
            chk1("t4_busy_low", busy, 1'b0);
            i2c_stop();
        end
        chk32("t4_no_strobe", st_addr.size(), n0);

        // pointer wrap 0xFF -> 0x00
        n0 = st_addr.size();
        i2c_start();
        addr_phase(7'h68, 1'b0, ln);
        reg_byte(8'hFF, ln);
        write_byte(8'h5A, ln);
        write_byte(8'hA5, ln);
        i2c_stop();
        chk32("t5_strobe_count", st_addr.size(), n0 + 2);
        if (st_addr.size() >= n0 + 2) begin
            chk8("t5_addr0", st_addr[n0], 8'hFF);
            chk8("t5_data0", st_data[n0], 8'h5A);
            chk8("t5_addr1", st_addr[n0 + 1], 8'h00);
            chk8("t5_data1", st_data[n0 + 1], 8'hA5);
        end

        // pointer survives STOP
        i2c_start();
        addr_phase(7'h68, 1'b0, ln);
        reg_byte(8'h11, ln);
        i2c_stop();
        i2c_start();
        addr_phase(7'h68, 1'b1, ln);
        read_byte(1'b1, b0);
        read_byte(1'b0, b1);
        i2c_stop();
        chk8("t6_unmapped_0x11", b0, 8'h00);
        chk8("t6_x_lsb_0x12", b1, 8'h34);

        // START after 4 bits of a read aborts it; next transaction proceeds
        i2c_start();
        addr_phase(7'h68, 1'b0, ln);
        reg_byte(8'h15, ln);
        i2c_start();
        addr_phase(7'h68, 1'b1, ln);
        e = mdl_reg(m_ptr);
        chk8("t7_model_byte", e, 8'hAB);
        for (int i = 7; i >= 4; i--) clock_bit(1'b1, ~e[i], ln);
        i2c_start();
        chk1("t7_oe_released", sda_oe, 1'b0);
        chk1("t7_busy_cleared", busy, 1'b0);
        n0 = st_addr.size();
        addr_phase(7'h68, 1'b0, l1);
        chk1("t7_readdr_ack", l1, 1'b0);
        reg_byte(8'h20, ln);
        write_byte(8'h11, ln);
        i2c_stop();
        chk32("t7_strobe_count", st_addr.size(), n0 + 1);
        if (st_addr.size() >= n0 + 1) begin
            chk8("t7_addr", st_addr[n0], 8'h20);
            chk8("t7_data", st_data[n0], 8'h11);
        end

        // reset while the address ACK is being driven
        i2c_start();
        send_bits({7'h68, 1'b0});
        m_busy = 1'b1;
        cyc(2 + Q);
        chk1("t8_ack_driven", sda_oe, 1'b1);
        @(negedge clk_50mhz);
        rst = 1'b1;
        @(posedge clk_50mhz);
        @(negedge clk_50mhz);
        chk1("t8_oe_after_rst", sda_oe, 1'b0);
        chk1("t8_busy_after_rst", busy, 1'b0);
        m_ptr  = 8'h00;
        m_busy = 1'b0;
        cyc(2);
        rst = 1'b0;
        cyc(4);
        i2c_stop();
        i2c_start();
        addr_phase(7'h68, 1'b1, ln);
        read_byte(1'b0, got);
        i2c_stop();
        chk8("t8_ptr_reset_chip_id", got, 8'hD1);

        cyc(10);
        chk32("write_queue_drained", exp_wq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
